ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly upstream of the memory stage. It accepts an R-type M-extension instruction with its two register operands. It computes the 32-bit result over multiple cycles and presents it on `result`, from which the core's EX/MEM mux drives `alu_out` into the memory stage. `busy` lets the core control logic freeze the PC and register-file writeback while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 72 +++++++
 rtl/ex_muldiv.sv | 165 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared radix-2 datapath: shift-add multiply into a 64-bit accumulator, or restoring
// shift-subtract divide with the quotient in acc[31:0] and the partial remainder alongside.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        div_mode,
    input  logic [31:0] load_a,
    input  logic [31:0] mag_b,
    output logic [63:0] acc_nxt,
    output logic [31:0] rem_nxt
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [32:0] mul_sum_s;
    logic [32:0] shifted_s;
    logic [32:0] diff_s;

    // One iteration of either algorithm, computed from the current registers.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b} : 33'd0);
        shifted_s = {rem_q, acc_q[31]};
        diff_s    = shifted_s - {1'b0, mag_b};
        acc_nxt   = acc_q;
        rem_nxt   = rem_q;
        if (div_mode) begin
            // A clear borrow bit means the divisor fit: keep the difference, quotient bit 1.
            if (!diff_s[32]) begin
                rem_nxt = diff_s[31:0];
                acc_nxt = {32'd0, acc_q[30:0], 1'b1};
            end else begin
                rem_nxt = shifted_s[31:0];
                acc_nxt = {32'd0, acc_q[30:0], 1'b0};
            end
        end else begin
            acc_nxt = {mul_sum_s, acc_q[31:1]};
            rem_nxt = rem_q;
        end
    end

    // Register update: load operand A, advance one step, or hold.
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        if (load) begin
            acc_d = {32'd0, load_a};
            rem_d = 32'd0;
        end else if (step) begin
            acc_d = acc_nxt;
            rem_d = rem_nxt;
        end else begin
            acc_d = acc_q;
            rem_d = rem_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 64'd0;
            rem_q <= 32'd0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: accept FSM, operand conditioning, special-case
// bypass and final sign fix-up around the shared muldiv_iter datapath.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic        neg_q, neg_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [2:0]  f3_s;
    logic        accept_s, special_s, div0_s, ovf_s;
    logic        sgn_a_s, sgn_b_s, neg_s, load_s;
    logic [31:0] mag_a_s, mag_b_s, spec_val_s, fin_val_s;
    logic [63:0] acc_nxt_s, prod_s;
    logic [31:0] rem_nxt_s;
    logic        unused_s;

    assign unused_s = ^{instruction[24:15], instruction[11:7]};
    assign f3_s     = instruction[14:12];
    assign accept_s = start && (instruction[6:0] == OPCODE_OP)
                      && (instruction[31:25] == FUNCT7_MULDIV)
                      && ((state_q == IDLE) || (state_q == DONE));

    // Operand conditioning: which operands are signed, their magnitudes, and special cases.
    always_comb begin
        sgn_a_s    = 1'b0;
        sgn_b_s    = 1'b0;
        spec_val_s = 32'd0;
        case (f3_s)
            F3_MULH, F3_DIV, F3_REM: begin
                sgn_a_s = dataA[31];
                sgn_b_s = dataB[31];
            end
            F3_MULHSU: sgn_a_s = dataA[31];
            default: begin
                sgn_a_s = 1'b0;
                sgn_b_s = 1'b0;
            end
        endcase
        mag_a_s = cond_neg(dataA, sgn_a_s);
        mag_b_s = cond_neg(dataB, sgn_b_s);
        neg_s   = (f3_s == F3_REM) ? sgn_a_s : (sgn_a_s ^ sgn_b_s);
        div0_s  = f3_s[2] && (dataB == 32'd0);
        ovf_s   = ((f3_s == F3_DIV) || (f3_s == F3_REM))
                  && (dataA == 32'h8000_0000) && (dataB == 32'hFFFF_FFFF);
        special_s = div0_s || ovf_s;
        case (f3_s)
            F3_DIV, F3_DIVU: spec_val_s = div0_s ? 32'hFFFF_FFFF : 32'h8000_0000;
            F3_REM, F3_REMU: spec_val_s = div0_s ? dataA : 32'd0;
            default:         spec_val_s = 32'd0;
        endcase
    end

    // Final result from the last iteration's outputs, so it can be registered on entry to DONE.
    always_comb begin
        prod_s = neg_q ? (64'd0 - acc_nxt_s) : acc_nxt_s;
        case (f3_q)
            F3_MUL:                      fin_val_s = prod_s[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_val_s = prod_s[63:32];
            F3_DIV, F3_DIVU:             fin_val_s = cond_neg(acc_nxt_s[31:0], neg_q);
            F3_REM, F3_REMU:             fin_val_s = cond_neg(rem_nxt_s, neg_q);
            default:                     fin_val_s = 32'd0;
        endcase
    end

    // Next-state logic for the accept/iterate/done FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        mag_b_d  = mag_b_q;
        result_d = result_q;
        load_s   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    f3_d    = f3_s;
                    neg_d   = neg_s;
                    mag_b_d = mag_b_s;
                    cnt_d   = 6'd0;
                    if (special_s) begin
                        result_d = spec_val_s;
                        state_d  = DONE;
                    end else begin
                        load_s  = 1'b1;
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    result_d = fin_val_s;
                    state_d  = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            f3_q     <= 3'd0;
            neg_q    <= 1'b0;
            mag_b_q  <= 32'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            mag_b_q  <= mag_b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    muldiv_iter u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .step    (state_q == CALC),
        .div_mode(f3_q[2]),
        .load_a  (mag_a_s),
        .mag_b   (mag_b_q),
        .acc_nxt (acc_nxt_s),
        .rem_nxt (rem_nxt_s)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: the driver pushes expected results from an arithmetic
// reference model; an independent monitor pops them whenever done is seen.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [31:0] dataA = 32'd0;
    logic [31:0] dataB = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned bcnt = 0;
    logic [31:0] model_result = 32'd0;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
        int unsigned blen;
    } exp_t;
    exp_t scb[$];

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {special, result} from the RV32M rules using plain wide arithmetic.
    function automatic logic [32:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0] pu;
        int ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin pu = {32'd0, a} * {32'd0, b}; return {1'b0, pu[31:0]}; end
            3'd1: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                        return {1'b0, ps[63:32]}; end
            3'd2: begin pu = {{32{a[31]}}, a} * {32'd0, b}; return {1'b0, pu[63:32]}; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return {1'b0, pu[63:32]}; end
            3'd4: begin
                if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
                return {1'b0, 32'(ia / ib)};
            end
            3'd5: return (b == 32'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            3'd6: begin
                if (b == 32'd0) return {1'b1, a};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'd0};
                return {1'b0, 32'(ia % ib)};
            end
            default: return (b == 32'd0) ? {1'b1, a} : {1'b0, a % b};
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        logic [14:0] regs;
        regs = 15'($urandom);
        return {f7, regs[14:5], f3, regs[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drive one start; returns the cycle in which done is due (entered at posedge+2).
    task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                         input bit use_exp, input logic [31:0] exp_res, input int unsigned exp_lat,
                         output int unsigned done_at);
        exp_t e;
        logic [32:0] r;
        start = 1'b1; instruction = instr; dataA = a; dataB = b;
        if (instr[6:0] == 7'h33 && instr[31:25] == 7'h01) begin
            r = ref_op(instr[14:12], a, b);
            e.res  = use_exp ? exp_res : r[31:0];
            e.cyc  = cyc + (use_exp ? exp_lat : (r[32] ? 1 : 33));
            e.blen = (e.cyc == cyc + 1) ? 0 : 32;
            scb.push_back(e);
            done_at = e.cyc;
        end else begin
            done_at = cyc + 1;
        end
        @(posedge clk); #2;
        start = 1'b0; instruction = $urandom; dataA = $urandom; dataB = $urandom;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin @(posedge clk); #2; end
    endtask

    // Monitor: pops the scoreboard on each done, otherwise checks that result holds.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0;
            end else begin
                if (busy) bcnt++;
                if (done) begin
                    if (scb.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
                    end else begin
                        e = scb.pop_front();
                        chk("result", result, e.res);
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                        chk("busy_len", 32'(bcnt), 32'(e.blen));
                        model_result = e.res;
                    end
                    bcnt = 0;
                end else begin
                    chk("result_hold", result, model_result);
                end
            end
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int unsigned lat;
    } dir_t;

    initial begin
        dir_t dirs[10];
        int unsigned done_at;
        logic [2:0] f3;

        dirs[0] = '{32'h022081B3, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        dirs[1] = '{mk(7'h01, 3'd1), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        dirs[2] = '{mk(7'h01, 3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        dirs[3] = '{mk(7'h01, 3'd2), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        dirs[4] = '{mk(7'h01, 3'd4), 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33};
        dirs[5] = '{mk(7'h01, 3'd6), 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33};
        dirs[6] = '{mk(7'h01, 3'd5), 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        dirs[7] = '{mk(7'h01, 3'd7), 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
        dirs[8] = '{mk(7'h01, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        dirs[9] = '{mk(7'h01, 3'd6), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);

        // Directed cases, alternating back-to-back and one idle cycle between them.
        for (int i = 0; i < 10; i++) begin
            issue(dirs[i].instr, dirs[i].a, dirs[i].b, 1'b1, dirs[i].res, dirs[i].lat, done_at);
            wait_until(done_at);
            repeat (i % 2) begin @(posedge clk); #2; end
        end
        repeat (2) begin @(posedge clk); #2; end

        // A non-M instruction must be ignored.
        issue(32'h006282B3, 32'd5, 32'd6, 1'b0, 32'd0, 0, done_at);
        chk("add_busy", 32'(busy), 32'd0);
        chk("add_done", 32'(done), 32'd0);
        repeat (3) begin @(posedge clk); #2; end

        // MUL followed by a MUL accepted in its DONE cycle.
        issue(mk(7'h01, 3'd0), 32'h0001_0003, 32'h0000_0105, 1'b0, 32'd0, 0, done_at);
        wait_until(done_at);
        issue(mk(7'h01, 3'd0), 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'd0, 0, done_at);
        wait_until(done_at);

        // A second start during CALC must not disturb the operation in flight.
        issue(mk(7'h01, 3'd5), 32'hCAFE_F00D, 32'h0000_0013, 1'b0, 32'd0, 0, done_at);
        repeat (4) begin @(posedge clk); #2; end
        start = 1'b1; instruction = mk(7'h01, 3'd0); dataA = 32'd9; dataB = 32'd9;
        @(posedge clk); #2 start = 1'b0;
        chk("calc_start_busy", 32'(busy), 32'd1);
        wait_until(done_at);
        repeat (2) begin @(posedge clk); #2; end

        // Reset in the 10th CALC cycle discards the operation.
        issue(mk(7'h01, 3'd1), 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 32'd0, 0, done_at);
        repeat (9) begin @(posedge clk); #2; end
        rst = 1'b1;
        scb.delete();
        model_result = 32'd0;
        @(posedge clk); #2 rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        repeat (40) begin @(posedge clk); #2; end

        // Randomized operations checked against the reference model.
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                issue(mk(7'($urandom_range(2, 127)), f3), rnd_operand(), rnd_operand(),
                      1'b0, 32'd0, 0, done_at);
            else
                issue(mk(7'h01, f3), rnd_operand(), rnd_operand(), 1'b0, 32'd0, 0, done_at);
            wait_until(done_at);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        repeat (5) begin @(posedge clk); #2; end
        chk("outstanding", 32'(scb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
